// File: rtl/shared_reg_arbiter_if.sv
// Bundle of the request/data/grant/status signals exchanged between the
// four requesters and the shared register arbiter.
interface shared_reg_arbiter_if #(
   parameter int WIDTH = 8
);
   logic [3:0]         req;
   logic [4*WIDTH-1:0] din;
   logic [3:0]         grant;
   logic [3:0]         ack;
   logic               busy;
   logic [WIDTH-1:0]   Q;
   logic [7:0]         wr_count;

   modport master (
      output req,
      output din,
      input  grant,
      input  ack,
      input  busy,
      input  Q,
      input  wr_count
   );

   modport slave (
      input  req,
      input  din,
      output grant,
      output ack,
      output busy,
      output Q,
      output wr_count
   );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter for four requesters sharing one register: each winning
// write takes exactly three cycles (arbitrate, load, acknowledge).
module shared_reg_arbiter #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   shared_reg_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       last_q, last_d;
   logic [3:0]       grant_q, grant_d;
   logic [3:0]       ack_q, ack_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [7:0]       wr_count_q, wr_count_d;

   logic             win_found;
   logic [1:0]       win_idx;
   logic [1:0]       cand;
   logic [WIDTH-1:0] din_sel;

   // Scan starts just after the last served requester, so it ends up lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_q;
      cand      = last_q;
      for (int k = 1; k <= 4; k++) begin
         cand = last_q + k[1:0];
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      din_sel = bus.din[WIDTH-1:0];
      for (int i = 0; i < 4; i++) begin
         if (sel_q == i[1:0]) begin
            din_sel = bus.din[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      last_d     = last_q;
      grant_d    = grant_q;
      ack_d      = ack_q;
      q_d        = q_q;
      wr_count_d = wr_count_q;

      unique case (state_q)
         IDLE: begin
            grant_d = 4'b0000;
            ack_d   = 4'b0000;
            if (win_found) begin
               state_d = LOAD;
               sel_d   = win_idx;
               grant_d = 4'b0001 << win_idx;
            end
         end
         LOAD: begin
            state_d    = ACK;
            q_d        = din_sel;
            ack_d      = 4'b0001 << sel_q;
            wr_count_d = wr_count_q + 8'd1;
         end
         ACK: begin
            state_d = IDLE;
            grant_d = 4'b0000;
            ack_d   = 4'b0000;
            last_d  = sel_q;
         end
         default: begin
            state_d = IDLE;
            grant_d = 4'b0000;
            ack_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= 2'd0;
         last_q     <= 2'd3;
         grant_q    <= 4'b0000;
         ack_q      <= 4'b0000;
         q_q        <= INIT_VAL;
         wr_count_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         q_q        <= q_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign bus.grant    = grant_q;
   assign bus.ack      = ack_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.Q        = q_q;
   assign bus.wr_count = wr_count_q;

   a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
   a_ack_in_grant : assert property (@(posedge clk) disable iff (rst) (ack_q & ~grant_q) == 4'b0000);
   a_ack_only_ack : assert property (@(posedge clk) disable iff (rst) (ack_q != 4'b0000) -> (state_q == ACK));

endmodule
